elastic_pipeline: RTL and testbench



---
 rtl/elastic_pipeline.sv | 95 +++++++++
 tb/tb_elastic_pipeline.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-stage valid/ready register pipeline.
// Stalls ripple back combinationally, so empty stages keep filling while
// the output is blocked. The pipeline also provides a synchronous flush and
// a registered occupancy count.
module elastic_pipeline #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    input  logic [WIDTH-1:0] in_data_in,
    output logic             in_ready_out,
    output logic             out_valid_out,
    output logic [WIDTH-1:0] out_data_out,
    input  logic             out_ready_in,
    output logic [CNT_W-1:0] count_out
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic [DEPTH-1:0] w_adv;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Advance ripple: a stage may load if it is empty or its successor moves
    always_comb begin
        logic w_chain;
        w_adv          = '0;
        w_chain        = !r_valid[DEPTH-1] | out_ready_in;
        w_adv[DEPTH-1] = w_chain;
        for (int unsigned j = 1; j < DEPTH; j++) begin
            w_chain                = !r_valid[DEPTH-1-j] | w_chain;
            w_adv[DEPTH-1-j]       = w_chain;
        end
    end

    assign in_ready_out  = w_adv[0] & !flush_in;
    assign w_in_xfer     = in_valid_in & in_ready_out;
    assign w_out_xfer    = r_valid[DEPTH-1] & out_ready_in;
    assign out_valid_out = r_valid[DEPTH-1];
    assign out_data_out  = r_data[DEPTH-1];
    assign count_out     = r_count;

    // Valid bits: flush empties every stage, otherwise advancing stages take their source valid
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid <= '0;
        end else if (flush_in) begin
            r_valid <= '0;
        end else begin
            if (w_adv[0]) r_valid[0] <= w_in_xfer;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (w_adv[i]) r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Data: load only real words so an empty pipeline keeps its last output value
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else if (!flush_in) begin
            if (w_in_xfer) r_data[0] <= in_data_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (w_adv[i] && r_valid[i-1]) r_data[i] <= r_data[i-1];
            end
        end
    end

    // Occupancy: +1 on accept, -1 on emit, unchanged when both happen
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
        end else if (flush_in) begin
            r_count <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_count_matches_valid: assert property (
        @(posedge clk_in) disable iff (!rst_n_in)
        r_count == CNT_W'($countones(r_valid))
    );

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: instances with DEPTH 3, 1 and 5 are checked
// every cycle against a word-position scoreboard model.
module tb_elastic_pipeline;

    localparam int NI = 3;
    localparam int DEP [NI] = '{3, 1, 5};

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [2:0] iv, ordy, fl;
    logic [7:0] idat [NI];
    logic [2:0] irdy, ov;
    logic [7:0] od [NI];
    logic [1:0] cnt3;
    logic [0:0] cnt1;
    logic [2:0] cnt5;
    logic [31:0] cnt [NI];

    int n_vec = 0;
    int n_err = 0;

    // scoreboard: words in acceptance order with their current stage index
    int         n   [NI];
    int         pos [NI][8];
    logic [7:0] dat [NI][8];

    always #5 clk_in = ~clk_in;

    assign cnt[0] = 32'(cnt3);
    assign cnt[1] = 32'(cnt1);
    assign cnt[2] = 32'(cnt5);

    elastic_pipeline #(.DEPTH(3), .WIDTH(8)) u_d3 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(fl[0]),
        .in_valid_in(iv[0]), .in_data_in(idat[0]), .in_ready_out(irdy[0]),
        .out_valid_out(ov[0]), .out_data_out(od[0]), .out_ready_in(ordy[0]),
        .count_out(cnt3));

    elastic_pipeline #(.DEPTH(1), .WIDTH(8)) u_d1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(fl[1]),
        .in_valid_in(iv[1]), .in_data_in(idat[1]), .in_ready_out(irdy[1]),
        .out_valid_out(ov[1]), .out_data_out(od[1]), .out_ready_in(ordy[1]),
        .count_out(cnt1));

    elastic_pipeline #(.DEPTH(5), .WIDTH(8)) u_d5 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(fl[2]),
        .in_valid_in(iv[2]), .in_data_in(idat[2]), .in_ready_out(irdy[2]),
        .out_valid_out(ov[2]), .out_data_out(od[2]), .out_ready_in(ordy[2]),
        .count_out(cnt5));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each word moves one stage per edge unless the word ahead blocks it;
    // the oldest word leaves from the last stage when the consumer is ready.
    task automatic model_edge(input int k);
        int         d;
        int         lim;
        int         m;
        int         np;
        int         npos [8];
        logic [7:0] ndat [8];
        bit         acc;
        d = DEP[k];
        if (fl[k]) begin
            n[k] = 0;
            return;
        end
        acc = iv[k] && (n[k] < d || ordy[k]);
        lim = d;
        m   = 0;
        for (int j = 0; j < n[k]; j++) begin
            if (j == 0 && pos[k][0] == d - 1 && ordy[k]) continue;
            np = pos[k][j] + 1;
            if (np > lim - 1) np = lim - 1;
            npos[m] = np;
            ndat[m] = dat[k][j];
            m++;
            lim = np;
        end
        if (acc) begin
            npos[m] = 0;
            ndat[m] = idat[k];
            m++;
        end
        for (int j = 0; j < m; j++) begin
            pos[k][j] = npos[j];
            dat[k][j] = ndat[j];
        end
        n[k] = m;
    endtask

    task automatic check_outputs(input int k);
        bit expv;
        expv = (n[k] > 0) && (pos[k][0] == DEP[k] - 1);
        check($sformatf("ovalid%0d", k), 32'(ov[k]), 32'(expv));
        if (expv) check($sformatf("odata%0d", k), 32'(od[k]), 32'(dat[k][0]));
        check($sformatf("count%0d", k), cnt[k], 32'(n[k]));
        check($sformatf("iready%0d", k), 32'(irdy[k]),
              32'(!fl[k] && (n[k] < DEP[k] || ordy[k])));
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge
    task automatic cycle();
        @(negedge clk_in);
        for (int k = 0; k < NI; k++) check_outputs(k);
        for (int k = 0; k < NI; k++) model_edge(k);
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle0(input int cycles);
        iv[0] = 1'b0;
        for (int c = 0; c < cycles; c++) cycle();
    endtask

    initial begin
        rst_n_in = 1'b0;
        iv = '0; ordy = '1; fl = '0;
        for (int k = 0; k < NI; k++) begin
            idat[k] = '0;
            n[k]    = 0;
        end
        #2;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_ov%0d", k), 32'(ov[k]), 32'd0);
            check($sformatf("rst_od%0d", k), 32'(od[k]), 32'd0);
            check($sformatf("rst_cnt%0d", k), cnt[k], 32'd0);
            check($sformatf("rst_ird%0d", k), 32'(irdy[k]), 32'd1);
        end
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        // back-to-back stream at full throughput
        for (int i = 1; i <= 10; i++) begin
            iv[0] = 1'b1; idat[0] = 8'(i);
            cycle();
            if (i >= 3) check("t1_cnt", cnt[0], 32'd3);
        end
        idle0(4);

        // fill while stalled, then a single emit+accept cycle
        ordy[0] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            iv[0] = 1'b1; idat[0] = 8'(8'h11 * i);
            cycle();
        end
        iv[0] = 1'b0;
        check("t2_cnt", cnt[0], 32'd3);
        check("t2_ird", 32'(irdy[0]), 32'd0);
        check("t2_od", 32'(od[0]), 32'h11);
        cycle();
        ordy[0] = 1'b1; iv[0] = 1'b1; idat[0] = 8'h44;
        cycle();
        check("t2_cnt2", cnt[0], 32'd3);
        check("t2_od2", 32'(od[0]), 32'h22);
        idle0(4);

        // bubble collapse under a stalled output
        ordy[0] = 1'b0;
        iv[0] = 1'b1; idat[0] = 8'hA1; cycle();
        idle0(2);
        iv[0] = 1'b1; idat[0] = 8'hA2; cycle();
        idle0(1);
        check("t3_cnt", cnt[0], 32'd2);
        check("t3_od", 32'(od[0]), 32'hA1);
        ordy[0] = 1'b1;
        cycle();
        check("t3_od2", 32'(od[0]), 32'hA2);
        idle0(3);

        // flush with a full pipeline and a word on offer
        ordy[0] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            iv[0] = 1'b1; idat[0] = 8'(i); cycle();
        end
        fl[0] = 1'b1; iv[0] = 1'b1; idat[0] = 8'h55;
        cycle();
        fl[0] = 1'b0; iv[0] = 1'b0;
        check("t4_ov", 32'(ov[0]), 32'd0);
        check("t4_cnt", cnt[0], 32'd0);
        ordy[0] = 1'b1; iv[0] = 1'b1; idat[0] = 8'h66;
        cycle();
        idle0(2);
        check("t4_ov2", 32'(ov[0]), 32'd1);
        check("t4_od2", 32'(od[0]), 32'h66);
        idle0(3);

        // asynchronous reset between edges while streaming
        for (int i = 0; i < 4; i++) begin
            iv[0] = 1'b1; idat[0] = 8'(8'hC0 + i); cycle();
        end
        #2 rst_n_in = 1'b0;
        #1;
        check("t5_ov", 32'(ov[0]), 32'd0);
        check("t5_cnt", cnt[0], 32'd0);
        check("t5_od", 32'(od[0]), 32'd0);
        for (int k = 0; k < NI; k++) n[k] = 0;
        iv[0] = 1'b0;
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        idle0(6);

        // random traffic on all three depths
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NI; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 9) < 6);
                fl[k]   = ($urandom_range(0, 63) == 0);
                idat[k] = 8'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
